// File: rtl/video_path_switch_if.sv
// Video path switch bus: the N_PATHS packed input streams, the
// selection controls and the selected output stream with status.
interface video_path_switch_if #(
    parameter int DATA_W  = 8,
    parameter int N_PATHS = 4,
    parameter int SEL_W   = 2
);
    logic [SEL_W-1:0]          sel_i;
    logic                      pattern_i;
    logic [N_PATHS*DATA_W-1:0] path_red_i;
    logic [N_PATHS*DATA_W-1:0] path_green_i;
    logic [N_PATHS*DATA_W-1:0] path_blue_i;
    logic [N_PATHS-1:0]        path_de_i;
    logic [N_PATHS-1:0]        path_hs_i;
    logic [N_PATHS-1:0]        path_vs_i;

    logic [DATA_W-1:0]         red_o;
    logic [DATA_W-1:0]         green_o;
    logic [DATA_W-1:0]         blue_o;
    logic                      de_o;
    logic                      hs_o;
    logic                      vs_o;
    logic [SEL_W-1:0]          active_sel_o;
    logic [3:0]                status_o;

    // Switch side: consumes the streams, produces the selected stream.
    modport slave (
        input  sel_i, pattern_i,
        input  path_red_i, path_green_i, path_blue_i,
        input  path_de_i, path_hs_i, path_vs_i,
        output red_o, green_o, blue_o, de_o, hs_o, vs_o,
        output active_sel_o, status_o
    );

    // Producer / sink side.
    modport master (
        output sel_i, pattern_i,
        output path_red_i, path_green_i, path_blue_i,
        output path_de_i, path_hs_i, path_vs_i,
        input  red_o, green_o, blue_o, de_o, hs_o, vs_o,
        input  active_sel_o, status_o
    );
endinterface

// File: rtl/video_path_switch.sv
// Frame-safe video path selector for hdmi_tx. Selection and colour-bar
// mode change only on a vsync rising edge of the active path; a vsync
// watchdog falls back to path 0 and blanks until path 0 delivers vsync.
module video_path_switch #(
    parameter int DATA_W  = 8,
    parameter int N_PATHS = 4,
    parameter int SEL_W   = 2,
    parameter int BAR_W   = 240,
    parameter int TIMEOUT = 4194304
) (
    input  logic                clk,
    input  logic                rst,
    video_path_switch_if.slave  vid
);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int PIX_W = $clog2(BAR_W + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_PATHS-1:0]  r_vs_prev;
    logic [SEL_W-1:0]    r_active_sel;
    logic                r_pattern_active;
    logic                r_bad_sel;
    logic                r_video_loss;
    logic [WD_W-1:0]     r_wd_cnt;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic [2:0]          r_bar_k;

    logic [DATA_W-1:0]   r_red, r_green, r_blue;
    logic                r_de, r_hs, r_vs;

    logic [DATA_W-1:0]   w_red, w_green, w_blue;
    logic                w_de, w_hs, w_vs, w_vs_prev;
    logic                w_vs_edge, w_expire, w_sel_ok, w_pending;
    logic [DATA_W-1:0]   w_red_nxt, w_green_nxt, w_blue_nxt;
    logic                w_de_nxt, w_hs_nxt, w_vs_nxt;
    logic [DATA_W-1:0]   w_bar_r, w_bar_g, w_bar_b;

    // Pick the currently active path out of the packed input buses.
    // NOTE: every always_comb output gets a default first, so no path through the block leaves a latch.
    always_comb begin
        w_red     = '0;
        w_green   = '0;
        w_blue    = '0;
        w_de      = 1'b0;
        w_hs      = 1'b0;
        w_vs      = 1'b0;
        w_vs_prev = 1'b0;
        for (int k = 0; k < N_PATHS; k++) begin
            if (r_active_sel == SEL_W'(k)) begin
                w_red     = vid.path_red_i[k*DATA_W +: DATA_W];
                w_green   = vid.path_green_i[k*DATA_W +: DATA_W];
                w_blue    = vid.path_blue_i[k*DATA_W +: DATA_W];
                w_de      = vid.path_de_i[k];
                w_hs      = vid.path_hs_i[k];
                w_vs      = vid.path_vs_i[k];
                w_vs_prev = r_vs_prev[k];
            end
        end
    end

    assign w_vs_edge = w_vs & ~w_vs_prev;
    assign w_expire  = (r_wd_cnt == WD_W'(TIMEOUT - 1));
    assign w_sel_ok  = (int'(vid.sel_i) < N_PATHS);
    // sel_i is a quasi-static switch; it is only acted on at a vsync edge.
    assign w_pending = (vid.sel_i != r_active_sel) || (vid.pattern_i != r_pattern_active);

    // Previous vsync of every path, so an edge is seen right after a switch.
    // NOTE: this input history is deliberately left out of reset, so a vsync already high through reset is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        r_vs_prev <= vid.path_vs_i;
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: watchdog expiry blanks, a vsync edge starts output.
    always_comb begin
        w_state_nxt = r_state;
        if (w_expire)       w_state_nxt = S_IDLE;
        else if (w_vs_edge) w_state_nxt = S_RUN;
    end

    // Selection, mode, status flags and vsync watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_sel     <= '0;
            r_pattern_active <= 1'b0;
            r_bad_sel        <= 1'b0;
            r_video_loss     <= 1'b0;
            r_wd_cnt         <= '0;
        end else if (w_expire) begin
            r_video_loss <= 1'b1;
            r_active_sel <= '0;
            r_wd_cnt     <= '0;
        end else if (w_vs_edge) begin
            r_wd_cnt         <= '0;
            r_video_loss     <= 1'b0;
            r_pattern_active <= vid.pattern_i;
            if (w_sel_ok) begin
                r_active_sel <= vid.sel_i;
                r_bad_sel    <= 1'b0;
            end else begin
                r_bad_sel    <= 1'b1;
            end
        end else if (r_wd_cnt != '1) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    // Colour-bar position within the line, driven by the active path's de.
    always_ff @(posedge clk) begin
        if (rst || !w_de) begin
            r_pix_cnt <= '0;
            r_bar_k   <= '0;
        end else if (r_pix_cnt == PIX_W'(BAR_W - 1)) begin
            r_pix_cnt <= '0;
            if (r_bar_k != 3'd7) r_bar_k <= r_bar_k + 3'd1;
        end else begin
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end
    end

    // Bar colour: white, yellow, cyan, green, magenta, red, blue, black.
    assign w_bar_r = {DATA_W{~r_bar_k[1]}};
    assign w_bar_g = {DATA_W{~r_bar_k[2]}};
    assign w_bar_b = {DATA_W{~r_bar_k[0]}};

    // FSM outputs: IDLE passes sync only, RUN passes the path or the bars.
    always_comb begin
        w_red_nxt   = '0;
        w_green_nxt = '0;
        w_blue_nxt  = '0;
        w_de_nxt    = 1'b0;
        w_hs_nxt    = w_hs;
        w_vs_nxt    = w_vs;
        if (r_state == S_RUN) begin
            w_de_nxt = w_de;
            if (r_pattern_active) begin
                if (w_de) begin
                    w_red_nxt   = w_bar_r;
                    w_green_nxt = w_bar_g;
                    w_blue_nxt  = w_bar_b;
                end
            end else begin
                w_red_nxt   = w_red;
                w_green_nxt = w_green;
                w_blue_nxt  = w_blue;
            end
        end
    end

    // Output register: one clock of latency for pixels and timing alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_de    <= 1'b0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
        end else begin
            r_red   <= w_red_nxt;
            r_green <= w_green_nxt;
            r_blue  <= w_blue_nxt;
            r_de    <= w_de_nxt;
            r_hs    <= w_hs_nxt;
            r_vs    <= w_vs_nxt;
        end
    end

    assign vid.red_o        = r_red;
    assign vid.green_o      = r_green;
    assign vid.blue_o       = r_blue;
    assign vid.de_o         = r_de;
    assign vid.hs_o         = r_hs;
    assign vid.vs_o         = r_vs;
    assign vid.active_sel_o = r_active_sel;
    assign vid.status_o     = {r_video_loss, r_bad_sel, w_pending, r_pattern_active};
endmodule

// File: tb/tb_video_path_switch.sv
// Bench for video_path_switch: common raster on all paths with random
// pixels per path, directed selection/pattern/watchdog/reset steps and a
// behavioural frame-level reference model checked every clock.
module tb_video_path_switch;
    localparam int DW    = 8;
    localparam int NP    = 4;
    localparam int SW    = 3;
    localparam int BW    = 4;
    localparam int TO    = 1000;
    localparam int LINE  = 48;
    localparam int ACT   = 40;
    localparam int LINES = 6;
    localparam int FRAME = LINE * LINES;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    video_path_switch_if #(.DATA_W(DW), .N_PATHS(NP), .SEL_W(SW)) vif ();

    video_path_switch #(
        .DATA_W(DW), .N_PATHS(NP), .SEL_W(SW), .BAR_W(BW), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif)
    );

    int errors = 0;
    int checks = 0;

    // Raster position of the inputs being presented this cycle.
    int h = 0;
    int v = 2;
    logic [NP-1:0] vs_kill = '0;

    // Reference model state, in frame-level terms.
    bit          m_run;
    int          m_sel;
    bit          m_pat, m_loss, m_bad;
    int          m_since_edge;
    int          m_line_pix;
    bit [NP-1:0] m_prev_vs;
    logic [23:0] e_rgb;
    logic [2:0]  e_tim;
    logic [23:0] bars [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        logic de, hs, vs;
        de = (v != 0) && (h < ACT);
        hs = (h >= 42) && (h < 46);
        vs = (v == 0);
        vif.path_de_i = {NP{de}};
        vif.path_hs_i = {NP{hs}};
        vif.path_vs_i = {NP{vs}} & ~vs_kill;
        for (int k = 0; k < NP; k++) begin
            vif.path_red_i[k*DW +: DW]   = DW'($urandom);
            vif.path_green_i[k*DW +: DW] = DW'($urandom);
            vif.path_blue_i[k*DW +: DW]  = DW'($urandom);
        end
    endtask

    // Expected outputs for the inputs now applied, then the model moves on.
    task automatic model_step();
        logic de, hs, vs, edge_seen;
        int a, bar;
        if (rst) begin
            m_run = 0; m_sel = 0; m_pat = 0; m_loss = 0; m_bad = 0;
            m_since_edge = 0; m_line_pix = 0;
            e_rgb = '0; e_tim = '0;
        end else begin
            a  = m_sel;
            de = vif.path_de_i[a];
            hs = vif.path_hs_i[a];
            vs = vif.path_vs_i[a];
            edge_seen = vs && !m_prev_vs[a];
            e_tim = {m_run ? de : 1'b0, hs, vs};
            if (!m_run) e_rgb = '0;
            else if (m_pat) begin
                bar = m_line_pix / BW;
                if (bar > 7) bar = 7;
                e_rgb = de ? bars[bar] : 24'h0;
            end else begin
                e_rgb = {vif.path_red_i[a*DW +: DW], vif.path_green_i[a*DW +: DW],
                         vif.path_blue_i[a*DW +: DW]};
            end
            m_line_pix = de ? m_line_pix + 1 : 0;
            if (m_since_edge == TO - 1) begin
                m_loss = 1; m_sel = 0; m_run = 0; m_since_edge = 0;
            end else if (edge_seen) begin
                m_since_edge = 0; m_run = 1; m_loss = 0; m_pat = vif.pattern_i;
                if (int'(vif.sel_i) < NP) begin m_sel = int'(vif.sel_i); m_bad = 0; end
                else m_bad = 1;
            end else begin
                m_since_edge++;
            end
        end
        m_prev_vs = vif.path_vs_i;
    endtask

    task automatic tick();
        bit pend;
        model_step();
        @(posedge clk);
        #1;
        pend = (int'(vif.sel_i) != m_sel) || (vif.pattern_i != m_pat);
        check("rgb", {vif.red_o, vif.green_o, vif.blue_o}, e_rgb);
        check("de_hs_vs", {vif.de_o, vif.hs_o, vif.vs_o}, e_tim);
        check("active_sel", vif.active_sel_o, m_sel);
        check("status", vif.status_o, {m_loss, m_bad, pend, m_pat});
        h++;
        if (h == LINE) begin h = 0; v = (v + 1) % LINES; end
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int vv, input int hh);
        for (int i = 0; i < FRAME && !(v == vv && h == hh); i++) tick();
    endtask

    initial begin
        int n;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        rst = 1'b1;
        vif.sel_i = '0;
        vif.pattern_i = 1'b0;
        drive_inputs();
        run(3);
        check("reset_status", vif.status_o, 4'h0);
        check("reset_de", vif.de_o, 1'b0);

        // Blank until the first path-0 vsync edge, then pass through.
        rst = 1'b0;
        run(2 * FRAME);

        // Mid-frame switch to path 2 waits for the frame boundary.
        run_to(3, 10);
        vif.sel_i = 3'd2;
        tick();
        check("pending_mid_frame", vif.status_o[1], 1'b1);
        check("sel_held_mid_frame", vif.active_sel_o, 3'd0);
        run(FRAME);
        check("sel_after_edge", vif.active_sel_o, 3'd2);
        check("pending_cleared", vif.status_o[1], 1'b0);

        // Out-of-range select is refused, then a valid one is taken.
        vif.sel_i = 3'd5;
        run(FRAME);
        check("bad_sel_set", vif.status_o[2], 1'b1);
        check("bad_sel_keeps_path", vif.active_sel_o, 3'd2);
        vif.sel_i = 3'd1;
        run(FRAME);
        check("bad_sel_clear", vif.status_o[2], 1'b0);
        check("sel_one", vif.active_sel_o, 3'd1);

        // Colour bars over two frames, then back to live video.
        vif.pattern_i = 1'b1;
        run(2 * FRAME);
        check("pattern_active", vif.status_o[0], 1'b1);
        vif.pattern_i = 1'b0;
        run(FRAME);

        // Path 2 loses vsync: watchdog falls back to path 0.
        vif.sel_i = 3'd2;
        run(FRAME);
        vs_kill = 4'b0100;
        n = 0;
        while (vif.status_o[3] !== 1'b1 && n < TO + 2 * FRAME) begin tick(); n++; end
        check("video_loss_set", vif.status_o[3], 1'b1);
        check("loss_sel_zero", vif.active_sel_o, 3'd0);
        check("loss_de_low", vif.de_o, 1'b0);
        vif.sel_i = 3'd0;
        run(FRAME);
        check("video_loss_clear", vif.status_o[3], 1'b0);
        vs_kill = '0;
        run(FRAME);

        // Reset across the boundary of a pending 0->3 switch.
        vif.sel_i = 3'd3;
        run_to(LINES - 1, LINE - 1);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        check("rst_sel_zero", vif.active_sel_o, 3'd0);
        run(FRAME);
        check("sel_three_next_frame", vif.active_sel_o, 3'd3);

        // Random selections and modes at random points in the frame.
        for (int f = 0; f < 12; f++) begin
            run($urandom_range(FRAME, 50));
            vif.sel_i = SW'($urandom_range(7, 0));
            vif.pattern_i = 1'($urandom_range(1, 0));
        end
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
